// File: rtl/rv_trap_t.sv
// rtl/rv_trap_t.sv - shared trap types: FSM states, cause encodings, interrupt priority
//
// Purpose: common declarations for trap_handler and trap_irq_arbiter.
//   trap_state_e   : trap sequencing FSM states
//   exc_cause_e    : synchronous exception cause codes (mcause[5:0], interrupt flag clear)
//   irq_cause_e    : interrupt cause codes (bit n of mip/mie)
//   IRQ_PRIO       : interrupt arbitration order, highest priority first
//   MTVEC_VECTORED : mtvec[1:0] mode value that selects vectored interrupt entry
// Ports: none (package).
package rv_trap_t;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FLUSH      = 3'd1,
      ST_WAIT_DRAIN = 3'd2,
      ST_CSR_WR     = 3'd3,
      ST_REDIRECT   = 3'd4
   } trap_state_e;

   typedef enum logic [5:0] {
      EXC_INST_MISALIGN  = 6'd0,
      EXC_INST_FAULT     = 6'd1,
      EXC_INST_ILLEGAL   = 6'd2,
      EXC_BREAKPOINT     = 6'd3,
      EXC_LOAD_MISALIGN  = 6'd4,
      EXC_LOAD_FAULT     = 6'd5,
      EXC_STORE_MISALIGN = 6'd6,
      EXC_STORE_FAULT    = 6'd7,
      EXC_ECALL_U        = 6'd8,
      EXC_ECALL_S        = 6'd9,
      EXC_ECALL_M        = 6'd11
   } exc_cause_e;

   localparam int IRQ_CODE_W   = 4;
   localparam int NUM_IRQ_PRIO = 6;

   typedef enum logic [IRQ_CODE_W-1:0] {
      IRQ_S_SOFT  = 4'd1,
      IRQ_M_SOFT  = 4'd3,
      IRQ_S_TIMER = 4'd5,
      IRQ_M_TIMER = 4'd7,
      IRQ_S_EXT   = 4'd9,
      IRQ_M_EXT   = 4'd11
   } irq_cause_e;

   // Index 0 is the highest priority; unlisted mip bits never win.
   localparam irq_cause_e IRQ_PRIO [NUM_IRQ_PRIO] = '{
      IRQ_M_EXT, IRQ_M_SOFT, IRQ_M_TIMER, IRQ_S_EXT, IRQ_S_SOFT, IRQ_S_TIMER
   };

   localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/trap_irq_arbiter.sv
// rtl/trap_irq_arbiter.sv - fixed-priority interrupt encoder
//
// Purpose: picks the highest-priority pending interrupt when globally enabled.
// Ports:
//   mie_i      in   global machine interrupt enable (mstatus.MIE)
//   irq_pend_i in   mip & mie, bit n = interrupt code n
//   vld_o      out  an enabled interrupt is pending
//   cause_o    out  interrupt code of the winner (0 when vld_o is low)
module trap_irq_arbiter
   import rv_trap_t::*;
(
   input  logic                  mie_i,
   input  logic [11:0]           irq_pend_i,
   output logic                  vld_o,
   output logic [IRQ_CODE_W-1:0] cause_o
);

   // Walk from lowest to highest priority so the last hit is the winner.
   always_comb begin
      vld_o   = 1'b0;
      cause_o = '0;
      for (int k = NUM_IRQ_PRIO - 1; k >= 0; k--) begin
         if (mie_i && irq_pend_i[IRQ_PRIO[k]]) begin
            vld_o   = 1'b1;
            cause_o = IRQ_PRIO[k];
         end
      end
   end

endmodule

// File: rtl/trap_handler.sv
// rtl/trap_handler.sv - trap/mret sequencer: flush, CSR update, fetch redirect
//
// Purpose: arbitrates the ROB-head exception, pending interrupts and mret,
// then sequences IDLE -> FLUSH -> WAIT_DRAIN -> CSR_WR -> REDIRECT.
// Optional macro TRAP_TVAL_EN: when defined, o_mtval carries the latched
// exception tval; when undefined o_mtval is 0 and no tval register exists.
// Ports:
//   clk, rst                    core clock, synchronous active-low reset
//   i_exc_vld/cause/pc/tval     committing exception at the ROB head
//   i_mret_vld                  ROB head commits mret
//   i_irq_pend, i_mstatus_mie   pending enabled interrupts, global enable
//   i_mtvec, i_mepc             trap vector base/mode, mret return address
//   o_busy                      handler active, commit must stall
//   o_flush / i_flush_done      one-cycle flush pulse / backend drained
//   o_csr_we, o_mepc/mcause/mtval, o_mret / i_csr_ack   CSR update handshake
//   o_redirect_vld/pc           fetch redirect
module trap_handler
   import rv_trap_t::*;
#(
   parameter int XLEN    = 64,
   parameter int CAUSE_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_exc_vld,
   input  logic [CAUSE_W-1:0] i_exc_cause,
   input  logic [XLEN-1:0]    i_exc_pc,
   input  logic [XLEN-1:0]    i_exc_tval,
   input  logic               i_mret_vld,
   input  logic [11:0]        i_irq_pend,
   input  logic               i_mstatus_mie,
   input  logic [XLEN-1:0]    i_mtvec,
   input  logic [XLEN-1:0]    i_mepc,
   output logic               o_busy,
   output logic               o_flush,
   input  logic               i_flush_done,
   output logic               o_csr_we,
   output logic [XLEN-1:0]    o_mepc,
   output logic [XLEN-1:0]    o_mcause,
   output logic [XLEN-1:0]    o_mtval,
   output logic               o_mret,
   input  logic               i_csr_ack,
   output logic               o_redirect_vld,
   output logic [XLEN-1:0]    o_redirect_pc
);

   trap_state_e state_q, state_d;

   logic                  irq_vld;
   logic [IRQ_CODE_W-1:0] irq_cause;
   logic                  trap_take;
   logic                  accept;

   logic               intr_q, intr_d;
   logic               mret_q, mret_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic [XLEN-1:0]    pc_q, pc_d;
   logic [XLEN-1:0]    mtval_val;

   logic [XLEN-1:0]    mtvec_base;
   logic [XLEN-1:0]    vec_off;
   logic [XLEN-1:0]    trap_target;

   trap_irq_arbiter u_irq_arb (
      .mie_i      (i_mstatus_mie),
      .irq_pend_i (i_irq_pend),
      .vld_o      (irq_vld),
      .cause_o    (irq_cause)
   );

   assign trap_take = i_exc_vld || irq_vld;
   assign accept    = (state_q == ST_IDLE) && (trap_take || i_mret_vld);

   // Trap context latched at acceptance; an interrupt beats a same-cycle
   // exception, which simply re-traps after the interrupt handler.
   always_comb begin
      intr_d  = intr_q;
      mret_d  = mret_q;
      cause_d = cause_q;
      pc_d    = pc_q;
      if (accept) begin
         intr_d  = irq_vld;
         mret_d  = !trap_take;
         cause_d = irq_vld ? CAUSE_W'(irq_cause) : (i_exc_vld ? i_exc_cause : '0);
         pc_d    = i_exc_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         intr_q  <= 1'b0;
         mret_q  <= 1'b0;
         cause_q <= '0;
         pc_q    <= '0;
      end else begin
         intr_q  <= intr_d;
         mret_q  <= mret_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
      end
   end

`ifdef TRAP_TVAL_EN
   logic [XLEN-1:0] tval_q, tval_d;

   always_comb begin
      tval_d = tval_q;
      if (accept) begin
         tval_d = (i_exc_vld && !irq_vld) ? i_exc_tval : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tval_q <= '0;
      end else begin
         tval_q <= tval_d;
      end
   end

   assign mtval_val = tval_q;
`else
   logic unused_tval;
   assign unused_tval = ^i_exc_tval;
   assign mtval_val   = '0;
`endif

   // Vectored mode only applies to interrupts; the add wraps at XLEN bits.
   assign mtvec_base  = {i_mtvec[XLEN-1:2], 2'b00};
   assign vec_off     = {{(XLEN-CAUSE_W-2){1'b0}}, cause_q, 2'b00};
   assign trap_target = (intr_q && (i_mtvec[1:0] == MTVEC_VECTORED)) ?
                        (mtvec_base + vec_off) : mtvec_base;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:       if (accept) state_d = ST_FLUSH;
         ST_FLUSH:      state_d = ST_WAIT_DRAIN;
         ST_WAIT_DRAIN: if (i_flush_done) state_d = ST_CSR_WR;
         ST_CSR_WR:     if (i_csr_ack) state_d = ST_REDIRECT;
         ST_REDIRECT:   state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs. Gated by rst so every output drops while reset is held.
   always_comb begin
      o_busy         = 1'b0;
      o_flush        = 1'b0;
      o_csr_we       = 1'b0;
      o_mret         = 1'b0;
      o_mepc         = '0;
      o_mcause       = '0;
      o_mtval        = '0;
      o_redirect_vld = 1'b0;
      o_redirect_pc  = '0;
      if (rst) begin
         case (state_q)
            ST_IDLE: begin
               o_busy = accept;
            end
            ST_FLUSH: begin
               o_busy  = 1'b1;
               o_flush = 1'b1;
            end
            ST_WAIT_DRAIN: begin
               o_busy = 1'b1;
            end
            ST_CSR_WR: begin
               o_busy = 1'b1;
               if (mret_q) begin
                  o_mret = 1'b1;
               end else begin
                  o_csr_we = 1'b1;
                  o_mepc   = pc_q;
                  o_mcause = {intr_q, (XLEN-1)'(cause_q)};
                  o_mtval  = mtval_val;
               end
            end
            ST_REDIRECT: begin
               o_busy         = 1'b1;
               o_redirect_vld = 1'b1;
               o_redirect_pc  = mret_q ? {i_mepc[XLEN-1:1], 1'b0} : trap_target;
            end
            default: begin
               o_busy = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_handler.sv
// tb/tb_trap_handler.sv - self-checking bench for trap_handler
module tb_trap_handler;

   localparam int XLEN = 64;
`ifdef TRAP_TVAL_EN
   localparam bit TVAL_ON = 1'b1;
`else
   localparam bit TVAL_ON = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            i_exc_vld;
   logic [5:0]      i_exc_cause;
   logic [XLEN-1:0] i_exc_pc;
   logic [XLEN-1:0] i_exc_tval;
   logic            i_mret_vld;
   logic [11:0]     i_irq_pend;
   logic            i_mstatus_mie;
   logic [XLEN-1:0] i_mtvec;
   logic [XLEN-1:0] i_mepc;
   logic            o_busy;
   logic            o_flush;
   logic            i_flush_done;
   logic            o_csr_we;
   logic [XLEN-1:0] o_mepc;
   logic [XLEN-1:0] o_mcause;
   logic [XLEN-1:0] o_mtval;
   logic            o_mret;
   logic            i_csr_ack;
   logic            o_redirect_vld;
   logic [XLEN-1:0] o_redirect_pc;

   always #5 clk = ~clk;

   trap_handler #(.XLEN(64), .CAUSE_W(6)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_exc_vld      (i_exc_vld),
      .i_exc_cause    (i_exc_cause),
      .i_exc_pc       (i_exc_pc),
      .i_exc_tval     (i_exc_tval),
      .i_mret_vld     (i_mret_vld),
      .i_irq_pend     (i_irq_pend),
      .i_mstatus_mie  (i_mstatus_mie),
      .i_mtvec        (i_mtvec),
      .i_mepc         (i_mepc),
      .o_busy         (o_busy),
      .o_flush        (o_flush),
      .i_flush_done   (i_flush_done),
      .o_csr_we       (o_csr_we),
      .o_mepc         (o_mepc),
      .o_mcause       (o_mcause),
      .o_mtval        (o_mtval),
      .o_mret         (o_mret),
      .i_csr_ack      (i_csr_ack),
      .o_redirect_vld (o_redirect_vld),
      .o_redirect_pc  (o_redirect_pc)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        exc_vld;
      logic [5:0]  exc_cause;
      logic [63:0] exc_pc;
      logic [63:0] exc_tval;
      logic        mret_vld;
      logic [11:0] irq_pend;
      logic        mie;
      logic [63:0] mtvec;
      logic [63:0] mepc;
      int          drain_dly;
      int          ack_dly;
      logic        exp_taken;
      logic        exp_mret;
      logic [63:0] exp_mcause;
      logic [63:0] exp_mepc;
      logic [63:0] exp_mtval;
      logic [63:0] exp_target;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%h required=0x%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] tv(input logic [63:0] x);
      return TVAL_ON ? x : 64'h0;
   endfunction

   function automatic vec_t mk(input logic ev, input logic [5:0] ec, input logic [63:0] pc,
                               input logic [63:0] tval, input logic mr, input logic [11:0] irq,
                               input logic mie, input logic [63:0] mtvec, input logic [63:0] mepc,
                               input int d, input int a, input logic et, input logic em,
                               input logic [63:0] mc, input logic [63:0] mp,
                               input logic [63:0] mt, input logic [63:0] tg);
      vec_t v;
      v.exc_vld = ev; v.exc_cause = ec; v.exc_pc = pc; v.exc_tval = tval;
      v.mret_vld = mr; v.irq_pend = irq; v.mie = mie; v.mtvec = mtvec; v.mepc = mepc;
      v.drain_dly = d; v.ack_dly = a;
      v.exp_taken = et; v.exp_mret = em; v.exp_mcause = mc; v.exp_mepc = mp;
      v.exp_mtval = mt; v.exp_target = tg;
      return v;
   endfunction

   // Reference model: decide the winner from the rules, then build the CSR
   // values and redirect target with plain 64-bit arithmetic.
   function automatic vec_t model(input vec_t v);
      int prio [6];
      int winner;
      logic [63:0] base;
      vec_t r;
      r = v;
      prio = '{11, 3, 7, 9, 1, 5};
      winner = -1;
      if (v.mie) begin
         for (int i = 0; i < 6; i++) begin
            if (winner < 0 && v.irq_pend[prio[i]]) winner = prio[i];
         end
      end
      r.exp_taken = (winner >= 0) || v.exc_vld || v.mret_vld;
      r.exp_mret  = (winner < 0) && !v.exc_vld && v.mret_vld;
      r.exp_mepc  = v.exc_pc;
      base = v.mtvec & ~64'h3;
      if (winner >= 0) begin
         r.exp_mcause = 64'h8000_0000_0000_0000 + 64'(winner);
         r.exp_mtval  = 64'h0;
         r.exp_target = (v.mtvec[1:0] == 2'd1) ? base + 64'(winner) * 64'd4 : base;
      end else if (v.exc_vld) begin
         r.exp_mcause = 64'(v.exc_cause);
         r.exp_mtval  = tv(v.exc_tval);
         r.exp_target = base;
      end else begin
         r.exp_mcause = 64'h0;
         r.exp_mtval  = 64'h0;
         r.exp_target = v.mepc & ~64'h1;
      end
      return r;
   endfunction

   task automatic clear_req();
      i_exc_vld     = 1'b0;
      i_exc_cause   = '0;
      i_exc_pc      = '0;
      i_exc_tval    = '0;
      i_mret_vld    = 1'b0;
      i_irq_pend    = '0;
      i_mstatus_mie = 1'b0;
      i_flush_done  = 1'b0;
      i_csr_ack     = 1'b0;
   endtask

   // Called just after a clock edge with the DUT idle.
   task automatic run_vec(input vec_t v, input int id);
      int          k, flush_cnt, flush_cyc, csr_cnt, csr_cyc, red_cyc;
      logic        seen_red, busy_ok, stable, bad;
      logic        r_we, r_mret;
      logic [63:0] r_mepc, r_mcause, r_mtval, r_pc;
      i_exc_vld = v.exc_vld; i_exc_cause = v.exc_cause; i_exc_pc = v.exc_pc;
      i_exc_tval = v.exc_tval; i_mret_vld = v.mret_vld; i_irq_pend = v.irq_pend;
      i_mstatus_mie = v.mie; i_mtvec = v.mtvec; i_mepc = v.mepc;
      i_flush_done = 1'b0; i_csr_ack = 1'b0;
      #1;
      chk($sformatf("v%0d.busy_accept", id), 64'(o_busy), 64'(v.exp_taken));
      @(posedge clk); #1;
      if (!v.exp_taken) begin
         clear_req();
         bad = 1'b0;
         repeat (3) begin
            if (o_busy || o_flush || o_csr_we || o_mret || o_redirect_vld) bad = 1'b1;
            @(posedge clk); #1;
         end
         chk($sformatf("v%0d.stays_idle", id), 64'(bad), 64'h0);
         return;
      end
      k = 1; flush_cnt = 0; flush_cyc = 0; csr_cnt = 0; csr_cyc = 0; red_cyc = 0;
      seen_red = 1'b0; busy_ok = 1'b1; stable = 1'b1;
      r_we = 1'b0; r_mret = 1'b0; r_mepc = '0; r_mcause = '0; r_mtval = '0; r_pc = '0;
      while (k < 60 && !seen_red) begin
         // Requests raised while busy must be ignored.
         i_exc_vld = 1'($urandom_range(0, 1)); i_exc_cause = 6'($urandom);
         i_exc_pc = {$urandom, $urandom}; i_exc_tval = {$urandom, $urandom};
         i_mret_vld = 1'($urandom_range(0, 1)); i_irq_pend = 12'($urandom);
         i_mstatus_mie = 1'($urandom_range(0, 1));
         #1;
         if (!o_busy) busy_ok = 1'b0;
         if (o_flush) begin flush_cnt++; flush_cyc = k; end
         if (o_csr_we || o_mret) begin
            if (csr_cnt == 0) begin
               csr_cyc = k; r_we = o_csr_we; r_mret = o_mret;
               r_mepc = o_mepc; r_mcause = o_mcause; r_mtval = o_mtval;
            end else if (o_csr_we !== r_we || o_mret !== r_mret || o_mepc !== r_mepc ||
                         o_mcause !== r_mcause || o_mtval !== r_mtval) begin
               stable = 1'b0;
            end
            csr_cnt++;
         end
         if (o_redirect_vld) begin seen_red = 1'b1; red_cyc = k; r_pc = o_redirect_pc; end
         i_flush_done = (flush_cnt > 0) && (k >= flush_cyc + 1 + v.drain_dly);
         i_csr_ack    = (csr_cnt > 0) && (k >= csr_cyc + v.ack_dly);
         if (seen_red) clear_req();
         @(posedge clk); #1;
         k++;
      end
      chk($sformatf("v%0d.redirect_seen", id), 64'(seen_red), 64'h1);
      chk($sformatf("v%0d.flush_pulses", id), 64'(flush_cnt), 64'h1);
      chk($sformatf("v%0d.busy_held", id), 64'(busy_ok), 64'h1);
      chk($sformatf("v%0d.latency", id), 64'(red_cyc), 64'(4 + v.drain_dly + v.ack_dly));
      chk($sformatf("v%0d.csr_cycles", id), 64'(csr_cnt), 64'(v.ack_dly + 1));
      chk($sformatf("v%0d.csr_stable", id), 64'(stable), 64'h1);
      chk($sformatf("v%0d.csr_we", id), 64'(r_we), 64'(!v.exp_mret));
      chk($sformatf("v%0d.mret", id), 64'(r_mret), 64'(v.exp_mret));
      if (!v.exp_mret) begin
         chk($sformatf("v%0d.mepc", id), r_mepc, v.exp_mepc);
         chk($sformatf("v%0d.mcause", id), r_mcause, v.exp_mcause);
         chk($sformatf("v%0d.mtval", id), r_mtval, v.exp_mtval);
      end
      chk($sformatf("v%0d.redirect_pc", id), r_pc, v.exp_target);
      #1;
      chk($sformatf("v%0d.idle_after", id), 64'({o_busy, o_redirect_vld}), 64'h0);
   endtask

   vec_t tbl [10];
   vec_t rv;

   initial begin
      tbl[0] = mk(1, 6'd2, 64'h8000_0010, 64'h13, 0, 12'h000, 0, 64'h8000_0100, 64'h0, 0, 0,
                  1, 0, 64'h2, 64'h8000_0010, tv(64'h13), 64'h8000_0100);
      tbl[1] = mk(0, 6'd0, 64'h1000, 64'hABC, 0, 12'h080, 1, 64'h8000_0101, 64'h0, 0, 0,
                  1, 0, 64'h8000_0000_0000_0007, 64'h1000, 64'h0, 64'h8000_011C);
      tbl[2] = mk(1, 6'd5, 64'h2000, 64'hDEAD, 0, 12'h808, 1, 64'h8000_0001, 64'h0, 1, 1,
                  1, 0, 64'h8000_0000_0000_000B, 64'h2000, 64'h0, 64'h8000_002C);
      tbl[3] = mk(0, 6'd0, 64'h10, 64'h0, 0, 12'h888, 0, 64'h100, 64'h0, 0, 0,
                  0, 0, 64'h0, 64'h0, 64'h0, 64'h0);
      tbl[4] = mk(0, 6'd0, 64'h3000, 64'h0, 1, 12'h000, 0, 64'h100, 64'h8000_2001, 0, 2,
                  1, 1, 64'h0, 64'h0, 64'h0, 64'h8000_2000);
      tbl[5] = mk(1, 6'd11, 64'h3000, 64'h55, 0, 12'h000, 0, 64'h4000_0003, 64'h0, 2, 5,
                  1, 0, 64'hB, 64'h3000, tv(64'h55), 64'h4000_0000);
      tbl[6] = mk(1, 6'd3, 64'h4000, 64'h77, 1, 12'h000, 1, 64'h100, 64'h9999, 0, 0,
                  1, 0, 64'h3, 64'h4000, tv(64'h77), 64'h100);
      tbl[7] = mk(0, 6'd0, 64'h5000, 64'h0, 0, 12'h800, 1, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0, 0, 0,
                  1, 0, 64'h8000_0000_0000_000B, 64'h5000, 64'h0, 64'h1C);
      tbl[8] = mk(0, 6'd0, 64'h10, 64'h0, 0, 12'h555, 1, 64'h100, 64'h0, 0, 0,
                  0, 0, 64'h0, 64'h0, 64'h0, 64'h0);
      tbl[9] = mk(0, 6'd0, 64'h6000, 64'h0, 0, 12'h022, 1, 64'h200, 64'h0, 0, 0,
                  1, 0, 64'h8000_0000_0000_0001, 64'h6000, 64'h0, 64'h200);

      rst = 1'b0;
      clear_req();
      i_mtvec = '0;
      i_mepc  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.ctrl", 64'({o_busy, o_flush, o_csr_we, o_mret, o_redirect_vld}), 64'h0);
      chk("reset.data", o_mepc | o_mcause | o_mtval | o_redirect_pc, 64'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

      // Reset taken while waiting for the backend to drain.
      i_exc_vld = 1'b1; i_exc_cause = 6'd4; i_exc_pc = 64'h7000; i_exc_tval = 64'h1;
      i_mtvec = 64'h100;
      @(posedge clk); #1;
      clear_req();
      @(posedge clk); #1;
      chk("rst_mid.in_drain_busy", 64'({o_busy, o_flush}), 64'h2);
      rst = 1'b0;
      i_exc_vld = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid.ctrl", 64'({o_busy, o_flush, o_csr_we, o_mret, o_redirect_vld}), 64'h0);
      chk("rst_mid.data", o_mepc | o_mcause | o_mtval | o_redirect_pc, 64'h0);
      rst = 1'b1;
      clear_req();
      @(posedge clk); #1;
      chk("rst_mid.idle", 64'(o_busy), 64'h0);
      run_vec(mk(1, 6'd7, 64'h7100, 64'h9, 0, 12'h000, 0, 64'h300, 64'h0, 0, 0,
                 1, 0, 64'h7, 64'h7100, tv(64'h9), 64'h300), 50);

      for (int i = 0; i < 40; i++) begin
         rv.exc_vld   = 1'($urandom_range(0, 1));
         rv.exc_cause = 6'($urandom_range(0, 15));
         rv.exc_pc    = {$urandom, $urandom};
         rv.exc_tval  = {$urandom, $urandom};
         rv.mret_vld  = ($urandom_range(0, 3) == 0);
         rv.irq_pend  = ($urandom_range(0, 2) == 0) ? 12'h0 : 12'($urandom);
         rv.mie       = 1'($urandom_range(0, 1));
         rv.mtvec     = {$urandom, $urandom};
         rv.mepc      = {$urandom, $urandom};
         rv.drain_dly = $urandom_range(0, 3);
         rv.ack_dly   = $urandom_range(0, 3);
         rv = model(rv);
         run_vec(rv, 100 + i);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/trap_handler.md
Name: trap_handler

Overview:
- Consumer end of the trap cause encoding: the commit stage and CSR unit raise exceptions and interrupts; this block arbitrates, sequences and retires them.
- Takes one committing exception from the ROB head plus pending machine/supervisor interrupts, and picks the winner.
- Drives a pipeline flush, writes mepc/mcause/mtval/mstatus through the CSR write port, then redirects fetch to the mtvec target.
- Also handles mret redirection. Sits between commit/ROB and the CSR file/frontend.

Parameters:
- XLEN, 64, data/pc width; mcause interrupt flag is bit XLEN-1.
- CAUSE_W, 6, width of the exception cause code, matching the 64-entry exception encoding.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk rising edge)
- i_exc_vld  in  1  ROB head commits with an exception
- i_exc_cause  in  CAUSE_W  exception code
- i_exc_pc  in  XLEN  pc of the faulting instruction
- i_exc_tval  in  XLEN  faulting address/instruction
- i_mret_vld  in  1  ROB head commits mret
- i_irq_pend  in  12  mip & mie, bit n = interrupt code n
- i_mstatus_mie  in  1  global machine interrupt enable
- i_mtvec  in  XLEN  mtvec value
- i_mepc  in  XLEN  current mepc (mret target)
- o_busy  out  1  handler active; commit must stall
- o_flush  out  1  one-cycle pipeline flush pulse
- i_flush_done  in  1  backend drained
- o_csr_we  out  1  CSR trap-write strobe
- o_mepc  out  XLEN  value written to mepc
- o_mcause  out  XLEN  value written to mcause
- o_mtval  out  XLEN  value written to mtval
- o_mret  out  1  mstatus restore strobe (MIE<=MPIE)
- i_csr_ack  in  1  CSR unit accepted the write
- o_redirect_vld  out  1  fetch redirect valid
- o_redirect_pc  out  XLEN  fetch target

Behaviour:
- All outputs are 0 at reset. Reset mid-operation returns the FSM to IDLE and drops every output the same cycle.
- FSM states: IDLE, FLUSH, WAIT_DRAIN, CSR_WR, REDIRECT.
- IDLE:
  - A trap is taken when i_exc_vld, or (i_mstatus_mie && |i_irq_pend[11:0]).
  - Priority: interrupt over exception, both seen in the same cycle. The exception instruction is not retired and re-traps after the interrupt handler.
  - mret is taken only if no trap is pending.
  - The winning cause, pc, tval and type are latched into internal registers, then next state is FLUSH.
- Interrupt arbitration order: mExter(11) > mSoft(3) > mTimer(7) > sExter(9) > sSoft(1) > sTimer(5). Other bits are ignored.
- FLUSH: o_flush=1 for exactly one cycle, then WAIT_DRAIN.
- WAIT_DRAIN: hold until i_flush_done=1; 0 extra cycles if it is already high on entry.
- CSR_WR:
  - For a trap: o_csr_we=1 with o_mepc=latched pc, o_mcause={intr,zero-extend cause}, o_mtval=latched tval (0 for interrupts).
  - For mret: o_mret=1 with o_csr_we=0.
  - Held stable until i_csr_ack, then REDIRECT.
- REDIRECT: o_redirect_vld=1 for one cycle, then IDLE.
  - Trap target: base=i_mtvec with bits[1:0] cleared.
  - If mtvec[1:0]==1 and the trap is an interrupt, target = base + (cause<<2). Otherwise target = base.
  - mret target = i_mepc sampled in REDIRECT, with bit 0 cleared.
- o_busy=1 in every state except IDLE, and is combinationally high in the IDLE cycle a trap or mret is accepted.
- New i_exc_vld/irq/mret are ignored while busy.
- Minimum latency from acceptance to redirect is 4 cycles.
- Width rules: cause is zero-extended to XLEN-1 bits and the flag occupies bit XLEN-1. Address addition wraps modulo 2^XLEN.

Optional Feature:
- TRAP_TVAL_EN
  - Defined: o_mtval carries the latched i_exc_tval for exceptions.
  - Undefined: o_mtval is tied to 0, the tval register is not instantiated, and i_exc_tval is unused.

Decomposition:
- Shared package rv_trap_t holds the trap FSM state enum, the interrupt priority list, and the MTVEC_VECTORED=1 constant. It reuses the existing exception/interrupt enums.
- One natural sub-module, trap_irq_arbiter: combinational fixed-priority encoder from i_irq_pend and MIE to {valid, cause}.

Test Plan:
- Exception: cause=2 (instIllegal), pc=0x8000_0010, tval=0x13, mtvec=0x8000_0100, drain and ack immediate.
  - flush pulse; CSR write mepc=0x8000_0010, mcause=2, mtval=0x13; redirect to 0x8000_0100, 4 cycles after acceptance.
- Vectored interrupt: irq_pend bit7, MIE=1, mtvec=0x8000_0101.
  - mcause=0x8000_0000_0000_0007; redirect to 0x8000_011C; mtval=0.
- Simultaneous: exception cause=5 with irq_pend bits 3 and 11.
  - mcause=interrupt 11; the exception is not reported.
- MIE=0 with irq_pend=0x888 and no exception.
  - No flush, busy stays 0.
- mret with mepc=0x8000_2001.
  - flush; o_mret=1 until ack; redirect to 0x8000_2000; o_csr_we stays 0.
- Stall and reset:
  - With ack delayed 5 cycles, the CSR outputs are held stable for all 6 cycles.
  - Taking rst=0 during WAIT_DRAIN gives all outputs 0 the next cycle, and the FSM is back in IDLE.
